// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light controller and its receive-side
// monitor: light codes, monitor states, error codes and the phase order.
package traffic_light_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;

  // Light code as driven on the wire; 2'b11 is never legal.
  typedef enum logic [1:0] {
    LIGHT_RED     = 2'b00,
    LIGHT_GREEN   = 2'b01,
    LIGHT_YELLOW  = 2'b10,
    LIGHT_ILLEGAL = 2'b11
  } light_e;

  typedef enum logic [1:0] {
    SYNC  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } mon_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_SEQ     = 2'b10;
  localparam logic [1:0] ERR_DWELL   = 2'b11;

  // Legal successor of a phase: Red -> Green -> Yellow -> Red.
  function automatic logic [1:0] next_light(input logic [1:0] code);
    case (code)
      RED:     next_light = GREEN;
      GREEN:   next_light = YELLOW;
      default: next_light = RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Connection between the light controller / supervisor side (master) and
// the monitor (slave).
interface traffic_light_monitor_if #(
  parameter int CNT_W = 8
) ();

  logic [1:0]       light;
  logic             err_clear;
  logic             in_sync;
  logic             fault;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output light, err_clear,
    input  in_sync, fault, err_code, cycle_count
  );

  modport slave (
    input  light, err_clear,
    output in_sync, fault, err_code, cycle_count
  );

endinterface

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic-light code. Locks on the first Red,
// then checks phase order, encoding and per-phase dwell time, and counts
// completed Yellow->Red transitions. Faults latch until err_clear.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 1,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  traffic_light_monitor_if.slave  bus
);

  localparam int DW = $clog2(MAX_DWELL + 1);
  localparam logic [DW-1:0] MIN_D = DW'(MIN_DWELL);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DWELL);
  localparam logic [DW-1:0] ONE_D = DW'(1);

  mon_state_e       state_q;
  light_e           cur_q;
  logic [DW-1:0]    dwell_q;
  logic             in_sync_q;
  logic             fault_q;
  logic [1:0]       err_code_q;
  logic [CNT_W-1:0] cycle_count_q;

  // Monitor FSM with registered outputs; every sample advances at most one step.
  // NOTE: all state here uses non-blocking assignments so every register sees
  // the pre-edge values of the others (cur_q is read for the Yellow->Red count
  // in the same edge it is overwritten).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SYNC;
      cur_q         <= LIGHT_RED;
      dwell_q       <= '0;
      in_sync_q     <= 1'b0;
      fault_q       <= 1'b0;
      err_code_q    <= ERR_NONE;
      cycle_count_q <= '0;
    end else begin
      case (state_q)
        SYNC: begin
          if (bus.light == RED) begin
            state_q   <= TRACK;
            cur_q     <= LIGHT_RED;
            dwell_q   <= ONE_D;
            in_sync_q <= 1'b1;
          end
        end

        TRACK: begin
          if (bus.light == LIGHT_ILLEGAL) begin
            state_q    <= FAULT;
            in_sync_q  <= 1'b0;
            fault_q    <= 1'b1;
            err_code_q <= ERR_ILLEGAL;
          end else if (bus.light == cur_q) begin
            if (dwell_q == MAX_D) begin
              state_q    <= FAULT;
              in_sync_q  <= 1'b0;
              fault_q    <= 1'b1;
              err_code_q <= ERR_DWELL;
            end else begin
              dwell_q <= dwell_q + ONE_D;
            end
          end else if (bus.light == next_light(cur_q)) begin
            if (dwell_q < MIN_D) begin
              state_q    <= FAULT;
              in_sync_q  <= 1'b0;
              fault_q    <= 1'b1;
              err_code_q <= ERR_DWELL;
            end else begin
              cur_q   <= light_e'(bus.light);
              dwell_q <= ONE_D;
              if (cur_q == LIGHT_YELLOW) begin
                cycle_count_q <= cycle_count_q + CNT_W'(1);
              end
            end
          end else begin
            state_q    <= FAULT;
            in_sync_q  <= 1'b0;
            fault_q    <= 1'b1;
            err_code_q <= ERR_SEQ;
          end
        end

        FAULT: begin
          if (bus.err_clear) begin
            state_q    <= SYNC;
            fault_q    <= 1'b0;
            err_code_q <= ERR_NONE;
          end
        end

        default: begin
          state_q   <= SYNC;
          in_sync_q <= 1'b0;
          fault_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_sync     = in_sync_q;
  assign bus.fault       = fault_q;
  assign bus.err_code    = err_code_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench: three monitors with different parameters see the
// same light stream and are compared against a phase-index reference model.
module tb_traffic_light_monitor;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  traffic_light_monitor_if #(.CNT_W(8)) if_a ();
  traffic_light_monitor_if #(.CNT_W(8)) if_b ();
  traffic_light_monitor_if #(.CNT_W(2)) if_c ();

  traffic_light_monitor #(.MIN_DWELL(1), .MAX_DWELL(1), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(if_a.slave));
  traffic_light_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .CNT_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(if_b.slave));
  traffic_light_monitor #(.MIN_DWELL(1), .MAX_DWELL(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(if_c.slave));

  // Reference model: phase tracked as an index into the legal order.
  int         p_min [3] = '{1, 2, 1};
  int         p_max [3] = '{1, 3, 1};
  int         p_mod [3] = '{256, 256, 4};
  logic [1:0] order [3] = '{2'b00, 2'b01, 2'b10};
  bit         m_locked [3];
  bit         m_fault  [3];
  logic [1:0] m_err    [3];
  int         m_count  [3];
  int         m_phase  [3];
  int         m_run    [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_locked[i] = 0; m_fault[i] = 0; m_err[i] = 2'b00;
      m_count[i] = 0; m_phase[i] = 0; m_run[i] = 0;
    end
  endtask

  task automatic model_fault(input int i, input logic [1:0] code);
    m_fault[i] = 1; m_locked[i] = 0; m_err[i] = code;
  endtask

  task automatic model_step(input logic [1:0] lt, input bit clr);
    for (int i = 0; i < 3; i++) begin
      if (m_fault[i]) begin
        if (clr) begin m_fault[i] = 0; m_err[i] = 2'b00; end
      end else if (!m_locked[i]) begin
        if (lt == 2'b00) begin m_locked[i] = 1; m_phase[i] = 0; m_run[i] = 1; end
      end else if (lt == 2'b11) begin
        model_fault(i, 2'b01);
      end else if (lt == order[m_phase[i]]) begin
        if (m_run[i] >= p_max[i]) model_fault(i, 2'b11);
        else m_run[i]++;
      end else if (lt == order[(m_phase[i] + 1) % 3]) begin
        if (m_run[i] < p_min[i]) model_fault(i, 2'b11);
        else begin
          if (m_phase[i] == 2) m_count[i] = (m_count[i] + 1) % p_mod[i];
          m_phase[i] = (m_phase[i] + 1) % 3;
          m_run[i] = 1;
        end
      end else begin
        model_fault(i, 2'b10);
      end
    end
  endtask

  function automatic logic [11:0] expected(input int i);
    expected = {m_locked[i], m_fault[i], m_err[i], 8'(m_count[i])};
  endfunction

  function automatic logic [11:0] observed(input int i);
    case (i)
      0:       observed = {if_a.in_sync, if_a.fault, if_a.err_code, if_a.cycle_count};
      1:       observed = {if_b.in_sync, if_b.fault, if_b.err_code, if_b.cycle_count};
      default: observed = {if_c.in_sync, if_c.fault, if_c.err_code, 6'b0, if_c.cycle_count};
    endcase
  endfunction

  // Drive one sample to all monitors, let one edge take it, update the model.
  task automatic step(input logic [1:0] lt, input bit clr);
    if_a.light = lt; if_b.light = lt; if_c.light = lt;
    if_a.err_clear = clr; if_b.err_clear = clr; if_c.err_clear = clr;
    @(posedge clk);
    model_step(lt, clr);
    #1;
  endtask

  task automatic apply_reset();
    if_a.light = 2'b01; if_b.light = 2'b01; if_c.light = 2'b01;
    if_a.err_clear = 1'b0; if_b.err_clear = 1'b0; if_c.err_clear = 1'b0;
    reset_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (observed(i) !== 12'h000) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d got=%h exp=%h", i, observed(i), 12'h000);
      end
    end
  endtask

  task automatic test_basic_sequence();
    logic [1:0] seq [7] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    apply_reset();
    for (int s = 0; s < 7; s++) begin
      step(seq[s], 1'b0);
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (observed(i) !== expected(i)) begin
          tests_failed++;
          $display("FAIL basic_seq step%0d dut%0d got=%h exp=%h", s, i, observed(i), expected(i));
        end
      end
    end
    tests_run++;
    if ({if_a.in_sync, if_a.fault, if_a.err_code, if_a.cycle_count} !== {1'b1, 1'b0, 2'b00, 8'd2}) begin
      tests_failed++;
      $display("FAIL basic_final got=%b/%b/%b/%0d exp=1/0/00/2",
               if_a.in_sync, if_a.fault, if_a.err_code, if_a.cycle_count);
    end
  endtask

  // Continues from the basic sequence: dut_a is tracking at Red.
  task automatic test_illegal_code();
    logic [1:0] seq [5] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    bit         clr [5] = '{0, 0, 0, 1, 0};
    for (int s = 0; s < 5; s++) begin
      step(seq[s], clr[s]);
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (observed(i) !== expected(i)) begin
          tests_failed++;
          $display("FAIL illegal step%0d dut%0d got=%h exp=%h", s, i, observed(i), expected(i));
        end
      end
      if (s == 0 || s == 2) begin
        tests_run++;
        if ({if_a.fault, if_a.err_code} !== 3'b101) begin
          tests_failed++;
          $display("FAIL illegal_held step%0d got=%b%b exp=101", s, if_a.fault, if_a.err_code);
        end
      end
      if (s == 3) begin
        tests_run++;
        if ({if_a.in_sync, if_a.fault, if_a.err_code} !== 4'b0000) begin
          tests_failed++;
          $display("FAIL err_clear got=%b%b%b exp=0000", if_a.in_sync, if_a.fault, if_a.err_code);
        end
      end
    end
  endtask

  task automatic test_skip_green();
    apply_reset();
    step(2'b00, 1'b0);
    step(2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (observed(i) !== expected(i)) begin
        tests_failed++;
        $display("FAIL skip_green dut%0d got=%h exp=%h", i, observed(i), expected(i));
      end
    end
    tests_run++;
    if ({if_a.fault, if_a.err_code, if_a.cycle_count} !== {1'b1, 2'b10, 8'd0}) begin
      tests_failed++;
      $display("FAIL skip_green_code got=%b/%b/%0d exp=1/10/0", if_a.fault, if_a.err_code, if_a.cycle_count);
    end
  endtask

  task automatic test_dwell_window();
    logic [1:0] seq [13] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
                             2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};
    apply_reset();
    for (int s = 0; s < 13; s++) begin
      step(seq[s], 1'b0);
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (observed(i) !== expected(i)) begin
          tests_failed++;
          $display("FAIL dwell step%0d dut%0d got=%h exp=%h", s, i, observed(i), expected(i));
        end
      end
      if (s == 7 || s == 11) begin
        tests_run++;
        if ({if_b.fault, if_b.cycle_count} !== {1'b0, 8'd1}) begin
          tests_failed++;
          $display("FAIL dwell_ok step%0d got=%b/%0d exp=0/1", s, if_b.fault, if_b.cycle_count);
        end
      end
    end
    tests_run++;
    if ({if_b.fault, if_b.err_code} !== 3'b111) begin
      tests_failed++;
      $display("FAIL dwell_max got=%b%b exp=111", if_b.fault, if_b.err_code);
    end
    apply_reset();
    step(2'b00, 1'b0);
    step(2'b01, 1'b0);
    tests_run++;
    if ({if_b.fault, if_b.err_code} !== 3'b111) begin
      tests_failed++;
      $display("FAIL dwell_min got=%b%b exp=111", if_b.fault, if_b.err_code);
    end
  endtask

  task automatic test_count_wrap();
    apply_reset();
    step(2'b00, 1'b0);
    for (int c = 0; c < 5; c++) begin
      step(2'b01, 1'b0);
      step(2'b10, 1'b0);
      step(2'b00, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (observed(i) !== expected(i)) begin
        tests_failed++;
        $display("FAIL wrap dut%0d got=%h exp=%h", i, observed(i), expected(i));
      end
    end
    tests_run++;
    if (if_c.cycle_count !== 2'd1) begin
      tests_failed++;
      $display("FAIL wrap_count got=%0d exp=1", if_c.cycle_count);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    step(2'b00, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(2'b01, 1'b0);
      step(2'b10, 1'b0);
      step(2'b00, 1'b0);
    end
    step(2'b01, 1'b0);
    step(2'b11, 1'b0);
    step(2'b01, 1'b0);
    tests_run++;
    if ({if_a.fault, if_a.cycle_count} !== {1'b1, 8'd3}) begin
      tests_failed++;
      $display("FAIL pre_reset got=%b/%0d exp=1/3", if_a.fault, if_a.cycle_count);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (observed(i) !== 12'h000) begin
        tests_failed++;
        $display("FAIL async_reset dut%0d got=%h exp=%h", i, observed(i), 12'h000);
      end
    end
    reset_n = 1'b1;
    step(2'b01, 1'b0);
    tests_run++;
    if (if_a.in_sync !== 1'b0) begin
      tests_failed++;
      $display("FAIL resync_green got=%b exp=0", if_a.in_sync);
    end
    step(2'b00, 1'b0);
    tests_run++;
    if (if_a.in_sync !== 1'b1) begin
      tests_failed++;
      $display("FAIL resync_red got=%b exp=1", if_a.in_sync);
    end
  endtask

  task automatic test_random();
    logic [1:0] prev = 2'b00;
    logic [1:0] lt;
    int         r;
    bit         clr;
    apply_reset();
    for (int s = 0; s < 400; s++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30)      lt = prev;
      else if (r < 80) lt = (prev == 2'b00) ? 2'b01 : (prev == 2'b01) ? 2'b10 : 2'b00;
      else if (r < 85) lt = 2'b11;
      else             lt = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 99) < 15);
      step(lt, clr);
      if (lt != 2'b11) prev = lt;
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (observed(i) !== expected(i)) begin
          tests_failed++;
          $display("FAIL random step%0d dut%0d light=%b clr=%b got=%h exp=%h",
                   s, i, lt, clr, observed(i), expected(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_sequence();
    test_illegal_code();
    test_skip_green();
    test_dwell_window();
    test_count_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Receive-side checker for the 2-bit traffic-light code (00 Red, 01 Green, 10 Yellow) driven by the light controller. It samples the code every clock and locks onto the sequence at the first Red. From then on it checks legal order (Red→Green→Yellow→Red), legal encoding and per-phase dwell time, and counts completed cycles. It sits beside the controller in the intersection top level and drives fault indication to the supervisory logic.

## Interface
- MIN_DWELL, 1: minimum consecutive cycles a phase must be shown before advancing (≥1)
- MAX_DWELL, 1: maximum consecutive cycles a phase may be shown (≥MIN_DWELL)
- CNT_W, 8: width of completed-cycle counter
- clk  input  1  system clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- light  input  2  light code from controller, sampled every clk
- err_clear  input  1  one-cycle pulse; leaves FAULT, ignored in other states
- in_sync  output  1  high while in TRACK
- fault  output  1  high while in FAULT
- err_code  output  2  first error since last clear: 00 none, 01 illegal code, 10 bad sequence, 11 dwell violation
- cycle_count  output  CNT_W  completed Yellow→Red transitions, wraps modulo 2^CNT_W

## Operation
- Internal registers: state (SYNC/TRACK/FAULT), cur (last accepted phase code), dwell (width clog2(MAX_DWELL+1), cycles cur has been shown, entry cycle counts as 1).
- SYNC: light==00 → TRACK, cur=00, dwell=1. Any other value, including 11, is ignored; the block stays in SYNC.
- TRACK, checks per sample in priority order:
  - light==11 → FAULT, err_code=01.
  - light==cur: dwell==MAX_DWELL → FAULT, err_code=11; else dwell+1.
  - light==next(cur): dwell<MIN_DWELL → FAULT, err_code=11; else cur=light, dwell=1. If cur was 10 (Yellow→Red), cycle_count+1.
  - any other value → FAULT, err_code=10.
- next(): 00→01, 01→10, 10→00.
- FAULT: all inputs except err_clear ignored; err_code held; cycle_count frozen. err_clear → SYNC, err_code=00.
- cycle_count is cleared only by reset; it survives err_clear.
- The transition that causes a fault never increments cycle_count.

## Timing
- All outputs are registered. A sample taken at edge N is reflected in the outputs immediately after edge N, giving one cycle of latency from light to in_sync/fault/err_code/cycle_count.
- Reset (async assert, any time including mid-phase or in FAULT): state=SYNC, cur=00, dwell=0, in_sync=0, fault=0, err_code=00, cycle_count=0.
- The first edge after reset_n deasserts samples in SYNC. If the controller comes out of reset showing Red, in_sync rises after that first edge.
- Defaults (MIN=MAX=1) accept a controller that advances every clock. Holding any phase for 2 cycles is a dwell fault.
- err_clear is sampled only in FAULT. An err_clear edge does not sample light; SYNC evaluation starts on the next edge.
- cycle_count wraps from 2^CNT_W−1 to 0 with no flag.
- dwell saturates at MAX_DWELL; it cannot overflow because exceeding MAX_DWELL faults.

## Structure
- Shared package traffic_light_pkg holds:
  - light code constants RED=2'b00, GREEN=2'b01, YELLOW=2'b10;
  - the light enum type shared with the controller;
  - monitor state enum (SYNC, TRACK, FAULT);
  - err_code constants;
  - function next_light().
- Single module, no sub-module. The dwell counter and cycle counter are inline registers.

## Test plan
- Reset then light 00,01,10,00,01,10,00 one per clock (defaults) → in_sync=1 after first edge, fault=0, cycle_count=2, err_code=00.
- In TRACK, drive light=11 for one cycle → fault=1 and err_code=01 after that edge. Later 00 samples are ignored until an err_clear pulse, after which err_code=00 and in_sync=0.
- Sequence 00,10 (skip Green) → err_code=10, fault=1, cycle_count unchanged.
- MIN_DWELL=2, MAX_DWELL=3: Red×2, Green×3, Yellow×2, Red → no fault, cycle_count=1. Then Green×4 → err_code=11 on the 4th Green sample. Separately, Red×1 then Green → err_code=11.
- CNT_W=2: five full Red→Green→Yellow→Red cycles → cycle_count=1 (wrapped).
- Assert reset_n low mid-Green with fault=1 and cycle_count=3 → all outputs 0 immediately, asynchronously. After release, drive 01,00 → stays out of sync on 01, in_sync=1 after the 00 sample.
